// File: rtl/hdmi_packet_scheduler.sv
// HDMI data-island scheduler.
// Opens at most one data island per line inside horizontal blanking. The
// island is preamble, leading guard band, one or more 32-cycle packets and a
// trailing guard band. Packet slots go round-robin to the requesting sources.
// Every output comes straight from a flop so the TMDS mux sees clean timing.
module hdmi_packet_scheduler #(
    parameter int SCREEN_WIDTH = 640,
    parameter int FRAME_WIDTH  = 800,
    parameter int START_OFFSET = 2,
    parameter int NUM_SRC      = 4,
    parameter int MAX_PACKETS  = 2
) (
    input  logic               clk_pixel,
    input  logic               reset,
    input  logic [9:0]         cx,
    input  logic [NUM_SRC-1:0] req,
    output logic [1:0]         mode,
    output logic [NUM_SRC-1:0] grant,
    output logic               pkt_start,
    output logic [4:0]         pkt_index,
    output logic [4:0]         pkt_count
);

    // Parameter sanity: the whole island has to fit inside the blanking interval.
    if (START_OFFSET + 12 + 32 * MAX_PACKETS + 10 > FRAME_WIDTH - SCREEN_WIDTH) begin : g_bad_timing
        $error("hdmi_packet_scheduler: island does not fit in horizontal blanking");
    end
    if (NUM_SRC < 1 || NUM_SRC > 8) begin : g_bad_num_src
        $error("hdmi_packet_scheduler: NUM_SRC must be 1..8");
    end
    if (MAX_PACKETS < 1 || MAX_PACKETS > 18) begin : g_bad_max_packets
        $error("hdmi_packet_scheduler: MAX_PACKETS must be 1..18");
    end

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    localparam logic [9:0] DECISION_CX = 10'(SCREEN_WIDTH + START_OFFSET);
    localparam logic [4:0] MAX_COUNT   = 5'(MAX_PACKETS);

    localparam logic [1:0] MODE_CTRL     = 2'd0;
    localparam logic [1:0] MODE_PREAMBLE = 2'd1;
    localparam logic [1:0] MODE_GUARD    = 2'd2;
    localparam logic [1:0] MODE_DATA     = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_LGUARD,
        S_DATA,
        S_TGUARD
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         phase_q, phase_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [4:0]         count_q, count_d;
    logic [1:0]         mode_q, mode_d;
    logic               pkt_start_q, pkt_start_d;
    logic [4:0]         pkt_index_q, pkt_index_d;

    logic               arb_found;
    logic [PTR_W-1:0]   arb_win;
    logic [PTR_W-1:0]   arb_next_ptr;
    logic [NUM_SRC-1:0] arb_grant;

    // Round-robin search starting at the pointer; first asserted request wins.
    always_comb begin
        int cand;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        arb_found = 1'b0;
        arb_win   = '0;
        cand      = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            if (!arb_found && req[cand[PTR_W-1:0]]) begin
                arb_found = 1'b1;
                arb_win   = cand[PTR_W-1:0];
            end
        end
        arb_next_ptr = (arb_win == PTR_W'(NUM_SRC - 1)) ? '0 : arb_win + PTR_W'(1);
        arb_grant    = NUM_SRC'(1) << arb_win;
    end

    // State register plus the registered outputs, synchronous active-high reset.
    always_ff @(posedge clk_pixel) begin
        // NOTE: flops take non-blocking assignments so every register updates from pre-edge values.
        if (reset) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            ptr_q       <= '0;
            grant_q     <= '0;
            count_q     <= '0;
            mode_q      <= MODE_CTRL;
            pkt_start_q <= 1'b0;
            pkt_index_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            count_q     <= count_d;
            mode_q      <= mode_d;
            pkt_start_q <= pkt_start_d;
            pkt_index_q <= pkt_index_d;
        end
    end

    // Next-state logic: phase timing, island start decision, packet-boundary arbitration.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q + 6'd1;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                phase_d = '0;
                grant_d = '0;
                count_d = '0;
                if (cx == DECISION_CX && |req) begin
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                if (phase_q == 6'd7) begin
                    state_d = S_LGUARD;
                    phase_d = '0;
                end
            end
            S_LGUARD, S_DATA: begin
                // Arbitrate on the last leading-guard cycle and on pkt_index 31.
                if ((state_q == S_LGUARD && phase_q == 6'd1) ||
                    (state_q == S_DATA && phase_q == 6'd31)) begin
                    phase_d = '0;
                    if (arb_found && count_q != MAX_COUNT) begin
                        state_d = S_DATA;
                        grant_d = arb_grant;
                        ptr_d   = arb_next_ptr;
                        count_d = count_q + 5'd1;
                    end else begin
                        state_d = S_TGUARD;
                        grant_d = '0;
                    end
                end
            end
            S_TGUARD: begin
                grant_d = '0;
                if (phase_q == 6'd1) begin
                    state_d = S_IDLE;
                    phase_d = '0;
                    count_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Output decode from the next state, so the registered outputs line up with state_q.
    always_comb begin
        mode_d      = MODE_CTRL;
        pkt_start_d = 1'b0;
        pkt_index_d = '0;
        case (state_d)
            S_PRE:              mode_d = MODE_PREAMBLE;
            S_LGUARD, S_TGUARD: mode_d = MODE_GUARD;
            S_DATA: begin
                mode_d      = MODE_DATA;
                pkt_index_d = phase_d[4:0];
                pkt_start_d = (phase_d == 6'd0);
            end
            default:            mode_d = MODE_CTRL;
        endcase
    end

    assign mode      = mode_q;
    assign grant     = grant_q;
    assign pkt_start = pkt_start_q;
    assign pkt_index = pkt_index_q;
    assign pkt_count = count_q;

endmodule

// File: doc/hdmi_packet_scheduler.md
Name: hdmi_packet_scheduler

Overview:
- Schedules HDMI data-island periods inside horizontal blanking and shares the packet slots between packet sources: audio sample, ACR, AVI InfoFrame, audio InfoFrame.
- Sits between the video timing counters (cx/cy) and the TMDS channel mux.
- Tells the mux which period is active (control, preamble, guard band, packet data) and which source owns the current 32-cycle packet slot.

Parameters:
- SCREEN_WIDTH, 640, active pixels per line.
- FRAME_WIDTH, 800, total pixels per line.
- START_OFFSET, 2, cycles after active video ends at which an island may start.
- NUM_SRC, 4, number of packet requesters (range 1..8).
- MAX_PACKETS, 2, max packets per island (range 1..18). Elaboration error if START_OFFSET+12+32*MAX_PACKETS+10 > FRAME_WIDTH-SCREEN_WIDTH.

Ports:
- clk_pixel  in  1  pixel clock
- reset  in  1  reset
- cx  in  10  current pixel column, increments each cycle, wraps at FRAME_WIDTH-1
- req  in  NUM_SRC  per-source packet request, level
- mode  out  2  0=CTRL, 1=DI_PREAMBLE, 2=DI_GUARD, 3=DI_DATA
- grant  out  NUM_SRC  one-hot owner of the current packet slot, 0 outside DI_DATA
- pkt_start  out  1  pulse on the first cycle of each packet
- pkt_index  out  5  cycle position within the packet, 0..31
- pkt_count  out  5  packets issued so far in the current island, including the current one

Behaviour:
- Interface decision: reset reset, synchronous, active-high; clock clk_pixel. All outputs registered.
- Reset values: mode=0, grant=0, pkt_start=0, pkt_index=0, pkt_count=0, state=IDLE, round-robin pointer=0.
- States:
  - IDLE: mode=CTRL.
  - PRE: 8 cycles, mode=DI_PREAMBLE.
  - LGUARD: 2 cycles, mode=DI_GUARD.
  - DATA: 32 cycles per packet, mode=DI_DATA.
  - TGUARD: 2 cycles, mode=DI_GUARD.
  - A 6-bit phase counter times each state.
- Decision cycle T: clock edge sampling cx==SCREEN_WIDTH+START_OFFSET in IDLE.
  - If |req, go to PRE. Outputs reflect PRE from cycle T+1.
  - Else stay IDLE; no island on this line.
- Timeline: PRE on T+1..T+8, LGUARD on T+9..T+10, packet 0 on T+11..T+42, packet k on T+11+32k..T+42+32k.
- Arbitration points: last LGUARD cycle, and pkt_index==31 of each packet.
  - req is sampled only at these points.
  - Round-robin: search starts at the pointer and wraps modulo NUM_SRC. The first asserted req wins. Pointer becomes winner+1 mod NUM_SRC.
  - grant is registered and held constant for all 32 cycles. pkt_start=1 and pkt_index=0 on the first cycle. pkt_count increments at each pkt_start.
- Packet-boundary decision:
  - At the last LGUARD cycle, req is guaranteed nonzero in practice. If it is 0 anyway, go to TGUARD with no packet; pkt_count stays 0.
  - At pkt_index==31, if no req or pkt_count==MAX_PACKETS, go to TGUARD: grant=0 and mode=DI_GUARD for 2 cycles, then IDLE/CTRL.
  - Otherwise start the next packet back-to-back with no gap.
- pkt_count holds its final value through TGUARD and clears on entry to IDLE.
- One island per line, including vertical-blanking lines. The decision compare is on cx only.
- Sources must hold req until they see their grant with pkt_start. Dropping req before its arbitration point forfeits the slot, with no error.
- Synchronous reset mid-island: next edge forces IDLE and reset values. No partial island resumes. The next decision cycle behaves normally.
- grant is never nonzero while mode!=DI_DATA. grant is always one-hot or zero.

Test Plan:
- NUM_SRC=4, req=0001 held through cycle T -> PRE T+1..T+8, GUARD T+9..T+10. grant=0001 T+11..T+42 with pkt_start only at T+11. Source then drops req -> GUARD T+43..T+44, CTRL at T+45.
- req=1111 constant, MAX_PACKETS=2 over 3 lines -> grants 0001,0010 / 0100,1000 / 0001,0010. pkt_count 1 then 2. Island ends after 2 packets.
- req=0 at every decision cycle for a full frame -> mode=0, grant=0, pkt_start=0 throughout.
- req=0100 dropped before the first pkt_index==31 -> exactly one packet, then TGUARD, pkt_count=1.
- Reset pulsed at T+20, mid-packet -> mode=0, grant=0, pkt_index=0 on the next cycle. Next line with req=0010 -> normal island granting 0010 first, since the pointer is reset.
- Assertion run with random req for 1000 lines -> grant one-hot/zero, grant!=0 only in DI_DATA, island ends by T+12+32*MAX_PACKETS+2 < FRAME_WIDTH-SCREEN_WIDTH-START_OFFSET-10 cycles.
